// File: rtl/rs232_tx_param.sv
// Parametrised RS-232 transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop; CLKS_PER_BIT clocks per bit.
// Optional line break generator enabled by defining RS232_TX_BREAK_EN.
module rs232_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] TxD_in,
    input  logic                 TxD_start,
`ifdef RS232_TX_BREAK_EN
    input  logic                 TxD_break,
`endif
    output logic                 TxD,
    output logic                 busy,
    output logic                 tx_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 1 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("rs232_tx_param: illegal parameter value");
    end

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
`ifdef RS232_TX_BREAK_EN
        , S_BREAK, S_MARK
`endif
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bit, par_n;
    logic                 txd_n, busy_n, done_n;
    logic                 bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            TxD     <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            par_bit <= par_n;
            TxD     <= txd_n;
            busy    <= busy_n;
            tx_done <= done_n;
        end
    end

    assign bit_end = (cnt == CNT_LAST);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par_bit;
        txd_n   = TxD;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                txd_n  = 1'b1;
                busy_n = 1'b0;
                cnt_n  = '0;
`ifdef RS232_TX_BREAK_EN
                if (TxD_break) begin
                    state_n = S_BREAK;
                    txd_n   = 1'b0;
                    busy_n  = 1'b1;
                end else
`endif
                if (TxD_start) begin
                    shreg_n = TxD_in;
                    par_n   = (PARITY == 1) ? ~^TxD_in : ^TxD_in;
                    txd_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                cnt_n = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    state_n = S_DATA;
                    idx_n   = '0;
                    txd_n   = shreg[0];
                end
            end
            S_DATA: begin
                cnt_n = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    // Shift so the next payload bit always sits at shreg[1].
                    shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
                    if (idx == DATA_LAST) begin
                        idx_n = '0;
                        if (PARITY != 0) begin
                            state_n = S_PAR;
                            txd_n   = par_bit;
                        end else begin
                            state_n = S_STOP;
                            txd_n   = 1'b1;
                        end
                    end else begin
                        idx_n = idx + 1'b1;
                        txd_n = shreg[1];
                    end
                end
            end
            S_PAR: begin
                cnt_n = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    state_n = S_STOP;
                    txd_n   = 1'b1;
                end
            end
            S_STOP: begin
                cnt_n = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    if (idx == STOP_LAST) begin
                        idx_n   = '0;
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
`ifdef RS232_TX_BREAK_EN
            S_BREAK: begin
                if (!TxD_break) begin
                    state_n = S_MARK;
                    txd_n   = 1'b1;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            S_MARK: begin
                cnt_n = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    if (idx == STOP_LAST) begin
                        idx_n   = '0;
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
                txd_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/rs232_tx_param.md
Name: rs232_tx_param

Overview:
Parametrised RS-232 serial transmitter, the next generation of the team's fixed 8N1, one-clock-per-bit transmitter. It adds these configurable features:
- data width, parity mode and stop-bit count;
- an integer baud divider;
- an asynchronous reset;
- a one-cycle completion pulse.

It sits between any byte-producing block (debug/telemetry muxes, DSP status dumpers) and the board TX pin.

Parameters:
- DATA_BITS, 8: payload bits per frame; legal 5..9.
- CLKS_PER_BIT, 1: clk cycles each serial bit is held; legal >=1. A value of 1 gives the legacy one-bit-per-clock timing.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame; legal 1..2.
- Illegal values are a compile-time error, raised by a generate-time check.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- TxD_in  in  DATA_BITS  payload; sampled only on the accepting edge.
- TxD_start  in  1  request to send; level-sampled.
- TxD  out  1  serial line; idle/mark = 1.
- busy  out  1  high while a frame (or break/mark-after-break) is in progress.
- tx_done  out  1  one-cycle pulse when a frame finishes.

Behaviour:
- Reset values (asynchronous): TxD=1, busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0.
- Frame length: P = 1 if PARITY != 0, else 0. F = (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles.
- States: IDLE -> START -> DATA -> PARITY (skipped when P=0) -> STOP -> IDLE. Every state is registered, and TxD is a registered output.
- Acceptance: when state is IDLE and TxD_start=1 at an edge, that edge:
  - latches TxD_in;
  - latches the parity bit (even: ^data; odd: ~^data);
  - drives TxD=0;
  - sets busy=1 and enters START.
- TxD_start is ignored whenever state is not IDLE. No queuing; the requester must hold TxD_start or retry.
- Bit timing: each bit is held exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and resets at every bit boundary.
- Data order: bits are sent LSB first, from bit 0 to bit DATA_BITS-1. The bit index wraps to 0 when leaving DATA.
- PARITY: one bit time carrying the latched parity bit.
- STOP: TxD=1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of frame:
  - The edge that ends the last stop cycle returns to IDLE, with busy=0 and tx_done=1 for exactly that one cycle.
  - busy is therefore high for exactly F cycles after the accepting edge.
  - The earliest next acceptance is the following edge, so there is a minimum of one idle mark cycle between back-to-back frames.
- TxD_in changes after acceptance do not affect the frame in flight.
- rst mid-frame: TxD returns to 1 and busy returns to 0 immediately. There is no tx_done, and the partial frame is abandoned.
- TxD_start held high continuously produces back-to-back frames every F+1 cycles.

Optional Feature:
Macro RS232_TX_BREAK_EN.
- Defined:
  - Adds input TxD_break (1 bit), placed after TxD_start.
  - When TxD_break=1 and state is IDLE, the block enters BREAK: TxD=0, busy=1, and TxD_start is ignored for as long as TxD_break stays high.
  - On TxD_break falling, the block enters MARK: TxD=1 for STOP_BITS*CLKS_PER_BIT cycles, then returns to IDLE.
  - A break never produces tx_done.
  - If TxD_break and TxD_start are both high in IDLE, the break wins.
  - TxD_break asserted mid-frame is ignored until IDLE is reached.
- Undefined: the port is absent, there are no BREAK/MARK states, and TxD is constant 1 in IDLE.

Test Plan:
1. DATA_BITS=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; pulse TxD_start with TxD_in=0xA5 -> TxD holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles; busy is high for 40 cycles; tx_done pulses once on the cycle busy falls.
2. PARITY=2 with TxD_in=0x07 -> parity slot = 1. PARITY=1 with the same data -> parity slot = 0. With STOP_BITS=2, the stop period is 2*CLKS_PER_BIT cycles high and busy is high for 48 cycles.
3. Pulse TxD_start again at cycle 10 of a frame, with a different TxD_in -> ignored: waveform unchanged, one tx_done. Hold TxD_start high -> frame starts every 41 cycles.
4. Assert rst at cycle 17 of a frame -> TxD=1 and busy=0 within the same cycle, no tx_done. After release, a new 0x3C frame is transmitted correctly.
5. CLKS_PER_BIT=1, 8N1 with 0x81 -> 10-cycle frame with bit-per-clock timing identical to the legacy transmitter.
6. RS232_TX_BREAK_EN defined: TxD_break high for 25 cycles from IDLE, with TxD_start also high -> TxD=0 for 25 cycles, then TxD=1 and busy high for 4 cycles (CLKS_PER_BIT=4), then idle. No frame is sent during the break and no tx_done is produced.
